// File: rtl/shared_adder_arb.sv
// shared_adder_arb: time-shares one W-bit adder between two requesters.
//   Round-robin arbitration on contention, operand capture on grant, registered
//   sum/carry/id and a one-cycle valid strobe. Sequence is IDLE -> CALC -> DONE.
// Build option: define SHARED_ADDER_SAT_EN for a saturating add (sum clamps to all
//   ones on overflow, carry flags the overflow); undefined gives a modular add with
//   the raw carry-out.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req0/opa0/opb0          requester 0 request and operand pair
//   req1/opa1/opb1          requester 1 request and operand pair
//   gnt0, gnt1              one-cycle pulse: that requester's operands were captured
//   busy                    high while an add is in flight (state != IDLE)
//   valid                   one-cycle pulse: sum, carry and id are valid
//   id                      requester owning the current result
//   sum, carry              registered result and carry/overflow flag
module shared_adder_arb #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0,
    input  logic [W-1:0] opa0,
    input  logic [W-1:0] opb0,
    input  logic         req1,
    input  logic [W-1:0] opa1,
    input  logic [W-1:0] opb1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         busy,
    output logic         valid,
    output logic         id,
    output logic [W-1:0] sum,
    output logic         carry
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic         winner_q, winner_d;
    logic         last_q, last_d;
    logic [W-1:0] opa_q, opa_d;
    logic [W-1:0] opb_q, opb_d;
    logic         gnt0_q, gnt0_d;
    logic         gnt1_q, gnt1_d;
    logic         busy_q, busy_d;
    logic         valid_q, valid_d;
    logic         id_q, id_d;
    logic [W-1:0] sum_q, sum_d;
    logic         carry_q, carry_d;
    logic         pick;
    logic [W:0]   full_sum;

    // Adder is W+1 bits wide so the carry-out is bit W.
    assign full_sum = {1'b0, opa_q} + {1'b0, opb_q};

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        last_d   = last_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        busy_d   = 1'b0;
        valid_d  = 1'b0;
        id_d     = id_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        pick     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // On contention the requester not served last wins.
                    pick     = (req0 && req1) ? ~last_q : req1;
                    winner_d = pick;
                    opa_d    = pick ? opa1 : opa0;
                    opb_d    = pick ? opb1 : opb0;
                    gnt0_d   = ~pick;
                    gnt1_d   = pick;
                    busy_d   = 1'b1;
                    state_d  = CALC;
                end
            end
            CALC: begin
                busy_d  = 1'b1;
                valid_d = 1'b1;
                id_d    = winner_q;
                carry_d = full_sum[W];
`ifdef SHARED_ADDER_SAT_EN
                sum_d   = full_sum[W] ? {W{1'b1}} : full_sum[W-1:0];
`else
                sum_d   = full_sum[W-1:0];
`endif
                state_d = DONE;
            end
            DONE: begin
                last_d  = winner_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            winner_q <= 1'b0;
            last_q   <= 1'b1;
            opa_q    <= '0;
            opb_q    <= '0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            id_q     <= 1'b0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            last_q   <= last_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            id_q     <= id_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
        end
    end

    assign gnt0  = gnt0_q;
    assign gnt1  = gnt1_q;
    assign busy  = busy_q;
    assign valid = valid_q;
    assign id    = id_q;
    assign sum   = sum_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_shared_adder_arb.sv
// tb_shared_adder_arb: transaction-level reference model plus per-cycle compare
//   for shared_adder_arb, directed scenarios with literal expectations, then
//   randomized requests with occasional asynchronous resets.
module tb_shared_adder_arb;
    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] opa0 = '0, opb0 = '0, opa1 = '0, opb1 = '0;
    logic         gnt0, gnt1, busy, valid, id, carry;
    logic [W-1:0] sum;

    shared_adder_arb #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .opa0(opa0), .opb0(opb0),
        .req1(req1), .opa1(opa1), .opb1(opb1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .valid(valid),
        .id(id), .sum(sum), .carry(carry)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted request at edge e shows its grant in the
    // cycle after e, its result one cycle later, and the next request can only
    // be sampled three edges after e.
    int           e = 0;
    int           next_free = 0;
    int           busy_until = 0;
    int           gnt_at = -10;
    int           res_at = -10;
    int           s;
    logic         m_last = 1'b1;
    logic         m_w;
    logic         p_win = 1'b0;
    logic [W-1:0] p_sum = '0;
    logic         p_carry = 1'b0;
    logic         e_gnt0 = 1'b0, e_gnt1 = 1'b0, e_busy = 1'b0, e_valid = 1'b0;
    logic         e_id = 1'b0, e_carry = 1'b0;
    logic [W-1:0] e_sum = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            e = 0; next_free = 0; busy_until = 0; gnt_at = -10; res_at = -10;
            m_last = 1'b1;
            e_gnt0 = 1'b0; e_gnt1 = 1'b0; e_busy = 1'b0; e_valid = 1'b0;
            e_id = 1'b0; e_carry = 1'b0; e_sum = '0;
        end else begin
            e++;
            if (e >= next_free && (req0 || req1)) begin
                m_w = (req0 && req1) ? !m_last : req1;
                s = m_w ? (int'(opa1) + int'(opb1)) : (int'(opa0) + int'(opb0));
                p_carry = (s >= (1 << W));
`ifdef SHARED_ADDER_SAT_EN
                p_sum = p_carry ? {W{1'b1}} : W'(s);
`else
                p_sum = W'(s);
`endif
                p_win = m_w;
                m_last = m_w;
                gnt_at = e; res_at = e + 1; busy_until = e + 2; next_free = e + 3;
            end
            e_gnt0  = (e == gnt_at) && !p_win;
            e_gnt1  = (e == gnt_at) && p_win;
            e_valid = (e == res_at);
            e_busy  = (e < busy_until);
            if (e_valid) begin
                e_sum = p_sum; e_carry = p_carry; e_id = p_win;
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        chk("gnt0", gnt0, e_gnt0);
        chk("gnt1", gnt1, e_gnt1);
        chk("busy", busy, e_busy);
        chk("valid", valid, e_valid);
        chk("id", id, e_id);
        chk("sum", sum, e_sum);
        chk("carry", carry, e_carry);
        chk("gnt_exclusive", gnt0 & gnt1, 0);
        chk("gnt_valid_exclusive", (gnt0 | gnt1) & valid, 0);
    end

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        nxt();
        nxt();
        rst_n = 1'b1;
    endtask

`ifdef SHARED_ADDER_SAT_EN
    localparam logic [W-1:0] T3_SUM = 4'd15;
`else
    localparam logic [W-1:0] T3_SUM = 4'd3;
`endif

    int g;

    initial begin
        nxt();
        chk("rst_gnt0", gnt0, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_id", id, 0);
        chk("rst_sum", sum, 0);
        chk("rst_carry", carry, 0);
        nxt();
        rst_n = 1'b1;

        // Single requester 0: 3 + 4.
        req0 = 1'b1; opa0 = 4'd3; opb0 = 4'd4;
        nxt(); chk("t1_gnt0", gnt0, 1); req0 = 1'b0;
        nxt(); chk("t1_valid", valid, 1); chk("t1_id", id, 0);
        chk("t1_sum", sum, 7); chk("t1_carry", carry, 0);
        nxt();

        // Contention right after reset: 0 first, then 1, alternating.
        do_reset();
        req0 = 1'b1; opa0 = 4'd5; opb0 = 4'd1;
        req1 = 1'b1; opa1 = 4'd9; opb1 = 4'd2;
        nxt(); chk("t2_gnt0", gnt0, 1); chk("t2_gnt1_low", gnt1, 0);
        nxt(); chk("t2_valid0", valid, 1); chk("t2_id0", id, 0); chk("t2_sum0", sum, 6);
        nxt(); chk("t2_idle", busy, 0);
        nxt(); chk("t2_gnt1", gnt1, 1);
        nxt(); chk("t2_valid1", valid, 1); chk("t2_id1", id, 1);
        chk("t2_sum1", sum, 11); chk("t2_carry1", carry, 0);
        nxt(); nxt(); chk("t2_gnt0_again", gnt0, 1);
        repeat (7) nxt();
        req0 = 1'b0; req1 = 1'b0;
        nxt();

        // Overflow: 12 + 7.
        req0 = 1'b1; opa0 = 4'd12; opb0 = 4'd7;
        nxt(); req0 = 1'b0;
        nxt(); chk("t3_sum", sum, T3_SUM); chk("t3_carry", carry, 1);
        nxt();

        // Operand change after capture; req1 raised during CALC.
        req0 = 1'b1; opa0 = 4'd6; opb0 = 4'd5;
        nxt(); chk("t4_gnt0", gnt0, 1);
        opa0 = 4'd15; req0 = 1'b0; req1 = 1'b1; opa1 = 4'd1; opb1 = 4'd1;
        nxt(); chk("t4_sum", sum, 11); chk("t4_id", id, 0); chk("t4_no_gnt1", gnt1, 0);
        nxt(); chk("t4_idle", busy, 0); chk("t4_no_gnt1_idle", gnt1, 0);
        nxt(); chk("t4_gnt1", gnt1, 1); req1 = 1'b0;
        nxt(); chk("t4_sum1", sum, 2); chk("t4_id1", id, 1);
        nxt();

        // Asynchronous reset during CALC.
        req0 = 1'b1; opa0 = 4'd2; opb0 = 4'd2;
        nxt(); chk("t5_gnt0", gnt0, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_async_gnt0", gnt0, 0); chk("t5_async_busy", busy, 0);
        chk("t5_async_sum", sum, 0); chk("t5_async_valid", valid, 0);
        req1 = 1'b1; opa1 = 4'd3; opb1 = 4'd3;
        nxt(); rst_n = 1'b1;
        nxt(); chk("t5_post_gnt0", gnt0, 1); chk("t5_post_gnt1", gnt1, 0); req0 = 1'b0;
        nxt(); chk("t5_sum", sum, 4);
        nxt(); nxt(); chk("t5_gnt1", gnt1, 1); req1 = 1'b0;
        nxt(); nxt();

        // Requester 1 held continuously.
        req1 = 1'b1; opa1 = 4'd7; opb1 = 4'd8;
        g = 0;
        repeat (9) begin nxt(); g += int'(gnt1); end
        chk("t6_gnt1_count", g, 3);
        req1 = 1'b0;
        nxt(); nxt(); nxt();

        // Randomized traffic honouring the handshake, with rare resets.
        for (int i = 0; i < 600; i++) begin
            nxt();
            if (!rst_n) rst_n = 1'b1;
            if (req0 && gnt0) req0 = ($urandom_range(0, 3) == 0);
            else if (!req0 && $urandom_range(0, 2) == 0) begin
                req0 = 1'b1; opa0 = W'($urandom); opb0 = W'($urandom);
            end
            if (req1 && gnt1) req1 = ($urandom_range(0, 3) == 0);
            else if (!req1 && $urandom_range(0, 2) == 0) begin
                req1 = 1'b1; opa1 = W'($urandom); opb1 = W'($urandom);
            end
            if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
        end
        rst_n = 1'b1; req0 = 1'b0; req1 = 1'b0;
        repeat (4) nxt();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
